// File: rtl/bounce_counter_ctrl.sv
// -----------------------------------------------------------------------------
// bounce_counter_ctrl
// Sequencer for an external loadable up/down counter. It drives enable,
// direction and load so that the counter bounces between latched bounds
// lo..hi. Supports run, pause, single-step, stop and counts turnarounds.
//
// Optional feature macro: BOUNCE_DWELL_EN
//   defined   : the TURN state holds for DWELL cycles (turn still pulses once)
//   undefined : the TURN state lasts exactly one cycle and DWELL is unused
//
// Ports
//   clk          clock, rising edge
//   clr_n        asynchronous active-low reset
//   i_start      level: run from IDLE, or resume from PAUSE
//   i_stop       level: abort to IDLE
//   i_pause      level: freeze in PAUSE
//   i_step       1-cycle pulse: one count while paused
//   i_lo, i_hi   bounds, latched on a start from IDLE
//   i_cnt_val    current counter value from the datapath
//   o_cnt_en     counter counts on the next edge
//   o_cnt_up     1 = +1, 0 = -1 (meaningful while o_cnt_en = 1)
//   o_cnt_load   counter loads o_load_val on the next edge
//   o_load_val   latched lo
//   o_busy       controller is not IDLE
//   o_turn       1-cycle pulse on each direction reversal
//   o_turn_cnt   reversals since the last start from IDLE (wraps)
//   o_cfg_err    last start from IDLE saw lo >= hi
// -----------------------------------------------------------------------------
module bounce_counter_ctrl #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DWELL = 2
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_pause,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_cnt_val,
   output logic             o_cnt_en,
   output logic             o_cnt_up,
   output logic             o_cnt_load,
   output logic [WIDTH-1:0] o_load_val,
   output logic             o_busy,
   output logic             o_turn,
   output logic [7:0]       o_turn_cnt,
   output logic             o_cfg_err
);

   // Two guard bits so that value-1 at zero stays negative in comparisons.
   localparam int unsigned XW = WIDTH + 2;
`ifdef BOUNCE_DWELL_EN
   localparam int unsigned TURN_CYC = DWELL;
`else
   localparam int unsigned TURN_CYC = 1;
`endif
   localparam int unsigned DW_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
   localparam logic signed [XW-1:0] ONE = XW'(1);

   if (DWELL < 1) begin : g_dwell_chk
      $error("bounce_counter_ctrl: DWELL must be >= 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_UP,
      ST_DOWN,
      ST_TURN,
      ST_PAUSE
   } state_t;

   state_t            r_state;
   logic              r_dir;
   logic [WIDTH-1:0]  r_lo_q;
   logic [WIDTH-1:0]  r_hi_q;
   logic              r_cnt_en;
   logic              r_cnt_up;
   logic              r_cnt_load;
   logic              r_busy;
   logic              r_turn;
   logic [7:0]        r_turn_cnt;
   logic              r_cfg_err;
   logic [DW_W-1:0]   r_dwell;

   logic signed [XW-1:0] w_cur;
   logic signed [XW-1:0] w_nxt;
   logic                 w_at_bound;
   logic                 w_adv;

   // Value the counter will hold after this edge, given the command it is
   // executing now. Deciding on this look-ahead lets the registered enable
   // drop exactly in the cycle the counter reaches a bound.
   always_comb begin
      w_cur = $signed({2'b00, i_cnt_val});
      if (r_cnt_load) begin
         w_nxt = $signed({2'b00, r_lo_q});
      end else if (r_cnt_en) begin
         w_nxt = r_cnt_up ? (w_cur + ONE) : (w_cur - ONE);
      end else begin
         w_nxt = w_cur;
      end
      w_at_bound = r_dir ? (w_nxt >= $signed({2'b00, r_hi_q}))
                         : (w_nxt <= $signed({2'b00, r_lo_q}));
   end

   // States that move on to UP/DOWN (or into TURN when at the facing bound).
   always_comb begin
      w_adv = 1'b0;
      case (r_state)
         ST_LOAD:         w_adv = 1'b1;
         ST_UP, ST_DOWN:  w_adv = !i_pause;
         ST_TURN:         w_adv = !i_pause && (r_dwell == '0);
         ST_PAUSE:        w_adv = i_start && !i_pause;
         default:         w_adv = 1'b0;
      endcase
   end

   // Sequencer: state, direction, bounds and all registered outputs.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state    <= ST_IDLE;
         r_dir      <= 1'b1;
         r_lo_q     <= '0;
         r_hi_q     <= '0;
         r_cnt_en   <= 1'b0;
         r_cnt_up   <= 1'b0;
         r_cnt_load <= 1'b0;
         r_busy     <= 1'b0;
         r_turn     <= 1'b0;
         r_turn_cnt <= '0;
         r_cfg_err  <= 1'b0;
         r_dwell    <= '0;
      end else begin
         r_cnt_en   <= 1'b0;
         r_cnt_up   <= 1'b0;
         r_cnt_load <= 1'b0;
         r_turn     <= 1'b0;

         if (i_stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_dwell <= '0;
         end else if (w_adv) begin
            r_busy <= 1'b1;
            if (w_at_bound) begin
               r_state    <= ST_TURN;
               r_dir      <= !r_dir;
               r_turn     <= 1'b1;
               r_turn_cnt <= r_turn_cnt + 8'd1;
               r_dwell    <= DW_W'(TURN_CYC - 1);
            end else begin
               r_state  <= r_dir ? ST_UP : ST_DOWN;
               r_cnt_en <= 1'b1;
               r_cnt_up <= r_dir;
            end
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (i_start && !i_pause) begin
                     if (i_lo < i_hi) begin
                        r_state    <= ST_LOAD;
                        r_busy     <= 1'b1;
                        r_dir      <= 1'b1;
                        r_lo_q     <= i_lo;
                        r_hi_q     <= i_hi;
                        r_turn_cnt <= '0;
                        r_cfg_err  <= 1'b0;
                        r_cnt_load <= 1'b1;
                     end else begin
                        r_cfg_err  <= 1'b1;
                     end
                  end
               end
               // Not advancing from UP/DOWN can only mean pause.
               ST_UP, ST_DOWN: begin
                  r_state <= ST_PAUSE;
               end
               ST_TURN: begin
                  if (i_pause) begin
                     r_state <= ST_PAUSE;
                     r_dwell <= '0;
                  end else begin
                     r_dwell <= r_dwell - DW_W'(1);
                  end
               end
               // Single step: count once, or reverse when already at the bound.
               ST_PAUSE: begin
                  if (i_step) begin
                     if (w_at_bound) begin
                        r_dir      <= !r_dir;
                        r_turn     <= 1'b1;
                        r_turn_cnt <= r_turn_cnt + 8'd1;
                     end else begin
                        r_cnt_en <= 1'b1;
                        r_cnt_up <= r_dir;
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_cnt_en   = r_cnt_en;
   assign o_cnt_up   = r_cnt_up;
   assign o_cnt_load = r_cnt_load;
   assign o_load_val = r_lo_q;
   assign o_busy     = r_busy;
   assign o_turn     = r_turn;
   assign o_turn_cnt = r_turn_cnt;
   assign o_cfg_err  = r_cfg_err;

endmodule
